// File: rtl/life_gen_scheduler.sv
// -----------------------------------------------------------------------------
// life_gen_scheduler
// Drives the generation register of the life map. It produces map_enable
// pulses at a programmable rate and drives the map's active-low reset. It
// supports run, pause, single-step and reloading of the seed pattern. It also
// counts generations and halts automatically on a still life or on extinction.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   run          level: 1 = free-run, 0 = pause
//   step         1-cycle pulse: advance one generation while paused
//   load_init    1-cycle pulse: reload seed pattern, clear counters
//   period       clocks per generation (values below 2 act as 2)
//   state_cur    current map contents
//   state_next   next-generation logic output
//   map_enable   registered 1-cycle update strobe to the map
//   map_reset_n  registered active-low reset to the map (re-arms seed load)
//   gen_count    generations applied since last load, saturating
//   stable       sticky: halted because state_next == state_cur
//   extinct      sticky: halted because state_cur == 0
//   fsm_state    CLEAR=0 LOAD=1 PAUSE=2 RUN=3 HALT=4
// -----------------------------------------------------------------------------
module life_gen_scheduler #(
    parameter int N  = 64,
    parameter int PW = 24,
    parameter int GW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          step,
    input  logic          load_init,
    input  logic [PW-1:0] period,
    input  logic [N-1:0]  state_cur,
    input  logic [N-1:0]  state_next,
    output logic          map_enable,
    output logic          map_reset_n,
    output logic [GW-1:0] gen_count,
    output logic          stable,
    output logic          extinct,
    output logic [2:0]    fsm_state
);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_LOAD  = 3'd1,
        S_PAUSE = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    localparam logic [PW-1:0] TICK_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] TICK_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] TICK_TWO  = {{(PW-2){1'b0}}, 2'b10};
    localparam logic [GW-1:0] GEN_ZERO  = {GW{1'b0}};
    localparam logic [GW-1:0] GEN_ONE   = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0] GEN_MAX   = {GW{1'b1}};

    state_e        fsm_q, fsm_d;
    logic [PW-1:0] tick_q, tick_d;
    logic          map_enable_q, map_enable_d;
    logic          map_reset_n_q, map_reset_n_d;
    logic [GW-1:0] gen_q, gen_d;
    logic          stable_q, stable_d;
    logic          extinct_q, extinct_d;

    logic [PW-1:0] eff_period_s;
    logic          tick_hit_s;
    logic          fire_s;

    assign eff_period_s = (period < TICK_TWO) ? TICK_TWO : period;
    // ">=" so that shrinking period below the current tick fires immediately.
    assign tick_hit_s   = (tick_q >= (eff_period_s - TICK_ONE));

    // Next-state, tick and output computation.
    always_comb begin
        fsm_d         = fsm_q;
        tick_d        = tick_q;
        map_enable_d  = 1'b0;
        map_reset_n_d = 1'b1;
        gen_d         = gen_q;
        stable_d      = stable_q;
        extinct_d     = extinct_q;
        fire_s        = 1'b0;

        case (fsm_q)
            S_CLEAR: begin
                // Move to LOAD: strobe the map once so it copies its seed.
                fsm_d        = S_LOAD;
                map_enable_d = 1'b1;
                tick_d       = TICK_ZERO;
                gen_d        = GEN_ZERO;
                stable_d     = 1'b0;
                extinct_d    = 1'b0;
            end
            S_LOAD: begin
                fsm_d = S_PAUSE;
            end
            S_PAUSE: begin
                tick_d = TICK_ZERO;
                if (load_init) begin
                    fsm_d         = S_CLEAR;
                    map_reset_n_d = 1'b0;
                end else if (step) begin
                    // A step right after a pulse is dropped so map_enable can
                    // never be high on two consecutive cycles.
                    fire_s = ~map_enable_q;
                end else if (run) begin
                    fsm_d = S_RUN;
                end else begin
                    fsm_d = S_PAUSE;
                end
            end
            S_RUN: begin
                if (load_init) begin
                    fsm_d         = S_CLEAR;
                    map_reset_n_d = 1'b0;
                    tick_d        = TICK_ZERO;
                end else if (!run) begin
                    fsm_d  = S_PAUSE;
                    tick_d = TICK_ZERO;
                end else if (tick_hit_s) begin
                    tick_d = TICK_ZERO;
                    fire_s = 1'b1;
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            S_HALT: begin
                if (load_init) begin
                    fsm_d         = S_CLEAR;
                    map_reset_n_d = 1'b0;
                end else begin
                    fsm_d = S_HALT;
                end
            end
            default: begin
                fsm_d         = S_CLEAR;
                map_reset_n_d = 1'b0;
                tick_d        = TICK_ZERO;
            end
        endcase

        // Generation compare: extinction outranks still life.
        if (fire_s) begin
            if (state_cur == {N{1'b0}}) begin
                extinct_d = 1'b1;
                fsm_d     = S_HALT;
            end else if (state_next == state_cur) begin
                stable_d = 1'b1;
                fsm_d    = S_HALT;
            end else begin
                map_enable_d = 1'b1;
                gen_d        = (gen_q == GEN_MAX) ? gen_q : (gen_q + GEN_ONE);
            end
        end else begin
            fire_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q         <= S_CLEAR;
            tick_q        <= TICK_ZERO;
            map_enable_q  <= 1'b0;
            map_reset_n_q <= 1'b0;
            gen_q         <= GEN_ZERO;
            stable_q      <= 1'b0;
            extinct_q     <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            tick_q        <= tick_d;
            map_enable_q  <= map_enable_d;
            map_reset_n_q <= map_reset_n_d;
            gen_q         <= gen_d;
            stable_q      <= stable_d;
            extinct_q     <= extinct_d;
        end
    end

    assign map_enable  = map_enable_q;
    assign map_reset_n = map_reset_n_q;
    assign gen_count   = gen_q;
    assign stable      = stable_q;
    assign extinct     = extinct_q;
    assign fsm_state   = fsm_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for life_gen_scheduler. An 8x8 life map is modelled around the
// scheduler. Each expected map_enable pulse (cycle and gen_count) is queued
// when the stimulus is driven. Pulses are popped and compared when seen.
// -----------------------------------------------------------------------------
module tb_life_gen_scheduler;

    localparam int N  = 64;
    localparam int PW = 24;
    localparam int GW = 16;

    logic          clock;
    logic          reset;
    logic          run;
    logic          step;
    logic          load_init;
    logic [PW-1:0] period;
    logic [N-1:0]  state_cur;
    logic [N-1:0]  state_next;
    logic          map_enable;
    logic          map_reset_n;
    logic [GW-1:0] gen_count;
    logic          stable;
    logic          extinct;
    logic [2:0]    fsm_state;

    typedef struct {
        int cyc;
        int gen;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [N-1:0] seed;
    logic [N-1:0] map_q = '0;
    logic         armed_q = 1'b0;

    life_gen_scheduler #(.N(N), .PW(PW), .GW(GW)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .load_init  (load_init),
        .period     (period),
        .state_cur  (state_cur),
        .state_next (state_next),
        .map_enable (map_enable),
        .map_reset_n(map_reset_n),
        .gen_count  (gen_count),
        .stable     (stable),
        .extinct    (extinct),
        .fsm_state  (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Game of Life step on an 8x8 grid without wrap-around.
    function automatic logic [N-1:0] life_next(input logic [N-1:0] m);
        logic [N-1:0] r;
        int cnt;
        r = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (!(dy == 0 && dx == 0) && (y + dy >= 0) && (y + dy < 8)
                            && (x + dx >= 0) && (x + dx < 8)) begin
                            cnt += int'(m[(y + dy) * 8 + (x + dx)]);
                        end
                    end
                end
                r[y * 8 + x] = (cnt == 3) || (m[y * 8 + x] && cnt == 2);
            end
        end
        return r;
    endfunction

    // Map register: map_reset_n low arms a seed load on the next enable.
    always @(posedge clock) begin
        if (!map_reset_n) begin
            armed_q <= 1'b1;
        end else if (map_enable) begin
            if (armed_q) begin
                map_q   <= seed;
                armed_q <= 1'b0;
            end else begin
                map_q <= life_next(map_q);
            end
        end
    end

    assign state_cur  = map_q;
    assign state_next = life_next(map_q);

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input int g);
        exp_t e;
        e.cyc = c;
        e.gen = g;
        sb_q.push_back(e);
    endtask

    // Pulse monitor: every map_enable must match the head of the scoreboard.
    always @(negedge clock) begin
        if (map_enable === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("pulse_cycle", cyc, e.cyc);
                check_val("pulse_gen", gen_count, e.gen);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_en"},   map_enable, 0);
        check_val({tag, "_rstn"}, map_reset_n, 0);
        check_val({tag, "_gen"},  gen_count, 0);
        check_val({tag, "_stab"}, stable, 0);
        check_val({tag, "_ext"},  extinct, 0);
        check_val({tag, "_fsm"},  fsm_state, 0);
    endtask

    // Called on a falling edge: holds reset for 'hold' cycles, then releases.
    task automatic do_reset(input int hold);
        reset     = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        load_init = 1'b0;
        repeat (hold) begin
            @(negedge clock);
            check_reset_vals("rst");
        end
        reset = 1'b0;
        push_exp(cyc + 1, 0);
        @(negedge clock);
        check_val("clr_rstn_high", map_reset_n, 1);
        check_val("clr_fsm_load", fsm_state, 1);
        @(negedge clock);
        check_val("load_fsm_pause", fsm_state, 2);
        check_val("load_gen", gen_count, 0);
    endtask

    localparam logic [N-1:0] BLINKER = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    localparam logic [N-1:0] BLOCK   = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);
    localparam logic [N-1:0] SINGLE  = (64'd1 << 27);

    initial begin
        int c;
        reset     = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        load_init = 1'b0;
        period    = 24'd5;
        seed      = BLINKER;
        @(negedge clock);

        // 1: reset and idle
        do_reset(1);
        repeat (3) @(negedge clock);
        check_val("idle_fsm", fsm_state, 2);
        check_val("idle_gen", gen_count, 0);

        // 2: blinker, period 5, run for 50 cycles
        period = 24'd5;
        c = cyc;
        run = 1'b1;
        for (int k = 1; k <= 9; k++) push_exp(c + 1 + 5 * k, k);
        repeat (50) @(negedge clock);
        run = 1'b0;
        repeat (2) @(negedge clock);
        check_val("blink_gen", gen_count, 9);
        check_val("blink_fsm", fsm_state, 2);
        check_val("blink_stable", stable, 0);
        check_val("blink_extinct", extinct, 0);

        // 3: block still life halts on first compare
        seed = BLOCK;
        do_reset(1);
        run = 1'b1;
        repeat (12) @(negedge clock);
        check_val("block_stable", stable, 1);
        check_val("block_fsm", fsm_state, 4);
        check_val("block_gen", gen_count, 0);
        check_val("block_extinct", extinct, 0);
        run = 1'b0;
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        repeat (3) @(negedge clock);
        check_val("block_halt_hold", fsm_state, 4);

        // 4: single cell dies, then extinction halt ignores step/run
        seed = SINGLE;
        do_reset(1);
        c = cyc;
        step = 1'b1;
        push_exp(c + 1, 1);
        @(negedge clock);
        step = 1'b0;
        repeat (2) @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        check_val("single_extinct", extinct, 1);
        check_val("single_fsm", fsm_state, 4);
        check_val("single_gen", gen_count, 1);
        check_val("single_stable", stable, 0);
        repeat (3) begin
            step = 1'b1;
            @(negedge clock);
            step = 1'b0;
            repeat (3) @(negedge clock);
        end
        run = 1'b1;
        repeat (10) @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        check_val("halt_hold_fsm", fsm_state, 4);
        check_val("halt_hold_gen", gen_count, 1);

        // 5: reload from HALT, three steps, then period 0 and 1 act as 2
        seed = BLINKER;
        c = cyc;
        load_init = 1'b1;
        push_exp(c + 2, 0);
        @(negedge clock);
        load_init = 1'b0;
        check_val("reload_rstn_low", map_reset_n, 0);
        check_val("reload_fsm_clear", fsm_state, 0);
        @(negedge clock);
        check_val("reload_fsm_load", fsm_state, 1);
        check_val("reload_extinct_clr", extinct, 0);
        check_val("reload_gen_clr", gen_count, 0);
        @(negedge clock);
        check_val("reload_fsm_pause", fsm_state, 2);
        for (int s = 1; s <= 3; s++) begin
            c = cyc;
            step = 1'b1;
            push_exp(c + 1, s);
            @(negedge clock);
            step = 1'b0;
            repeat (9) @(negedge clock);
        end
        check_val("step_gen", gen_count, 3);
        period = 24'd0;
        c = cyc;
        run = 1'b1;
        for (int k = 1; k <= 9; k++) push_exp(c + 1 + 2 * k, 3 + k);
        repeat (20) @(negedge clock);
        run = 1'b0;
        repeat (2) @(negedge clock);
        check_val("p0_gen", gen_count, 12);
        period = 24'd1;
        c = cyc;
        run = 1'b1;
        for (int k = 1; k <= 9; k++) push_exp(c + 1 + 2 * k, 12 + k);
        repeat (20) @(negedge clock);
        run = 1'b0;
        repeat (2) @(negedge clock);
        check_val("p1_gen", gen_count, 21);

        // 6: load_init + step mid-run, then reset during RUN
        period = 24'd4;
        c = cyc;
        run = 1'b1;
        push_exp(c + 5, 22);
        push_exp(c + 9, 23);
        repeat (10) @(negedge clock);
        load_init = 1'b1;
        step = 1'b1;
        push_exp(c + 12, 0);
        @(negedge clock);
        load_init = 1'b0;
        step = 1'b0;
        check_val("mid_rstn_low", map_reset_n, 0);
        check_val("mid_fsm_clear", fsm_state, 0);
        @(negedge clock);
        check_val("mid_fsm_load", fsm_state, 1);
        check_val("mid_gen_clr", gen_count, 0);
        push_exp(c + 18, 1);
        push_exp(c + 22, 2);
        repeat (13) @(negedge clock);
        check_val("mid_run_fsm", fsm_state, 3);
        do_reset(2);
        repeat (5) @(negedge clock);
        check_val("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
